ibex_id_instr_reg: RTL and testbench

IF/ID pipeline register that sits directly upstream of the instruction decoder. It captures fetched instructions from the IF stage using a valid/ready handshake and holds each instruction until ID signals completion. It supplies the decoder with the instruction word, a replicated ALU copy of that word, the compressed-illegal flag and first-cycle indication. It also tracks multi-cycle residency and handles flush and halt.

---
 rtl/ibex_id_instr_reg.sv | 185 ++++++++++++++++++
 tb/tb_ibex_id_instr_reg.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_id_instr_reg.sv
// IF/ID pipeline register: captures fetched instructions on a valid/ready handshake
// and holds each one for the decoder until ID reports completion, flush or reset.
module ibex_id_instr_reg #(
    parameter bit ResetAll     = 1'b1,
    parameter bit ReplicateAlu = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [15:0] fetch_rdata_c_i,
    input  logic        fetch_is_compressed_i,
    input  logic        fetch_illegal_c_i,
    input  logic        fetch_err_i,
    input  logic [31:0] fetch_pc_i,

    input  logic        id_done_i,
    input  logic        flush_i,
    input  logic        halt_i,

    output logic        instr_valid_id_o,
    output logic        instr_first_cycle_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_rdata_alu_id_o,
    output logic [15:0] instr_rdata_c_id_o,
    output logic        instr_is_compressed_id_o,
    output logic        illegal_c_insn_id_o,
    output logic        instr_fetch_err_o,
    output logic [31:0] pc_id_o,
    output logic [2:0]  instr_cycle_cnt_o
);

    localparam int unsigned InstrW = 32;
    localparam int unsigned CompW  = 16;
    localparam int unsigned CntW   = 3;
    localparam logic [CntW-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        IdEmpty = 2'd0,
        IdFirst = 2'd1,
        IdMulti = 2'd2
    } id_state_e;

    id_state_e         state_q, state_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fetch_ready;
    logic              accept;

    logic [InstrW-1:0] rdata_q, rdata_d;
    logic [CompW-1:0]  rdata_c_q, rdata_c_d;
    logic [InstrW-1:0] pc_q, pc_d;
    logic              is_c_q, is_c_d;
    logic              ill_c_q, ill_c_d;
    logic              err_q, err_d;

    // Handshake: a held instruction must retire (or the register be empty) before a new one lands.
    always_comb begin
        fetch_ready = ((state_q == IdEmpty) | id_done_i) & ~flush_i & ~halt_i;
        accept      = fetch_valid_i & fetch_ready;
    end

    assign fetch_ready_o = fetch_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IdEmpty;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IdEmpty: begin
                    if (accept) begin
                        state_d = IdFirst;
                        cnt_d   = '0;
                    end
                end
                IdFirst, IdMulti: begin
                    if (id_done_i) begin
                        state_d = accept ? IdFirst : IdEmpty;
                        cnt_d   = '0;
                    end else begin
                        state_d = IdMulti;
                        cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = IdEmpty;
                    cnt_d   = '0;
                end
            endcase
        end
        valid_d = (state_d != IdEmpty);
        first_d = (state_d == IdFirst);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IdEmpty;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath loads only on accept and otherwise holds.
    always_comb begin
        rdata_d   = accept ? fetch_rdata_i         : rdata_q;
        rdata_c_d = accept ? fetch_rdata_c_i       : rdata_c_q;
        pc_d      = accept ? fetch_pc_i            : pc_q;
        is_c_d    = accept ? fetch_is_compressed_i : is_c_q;
        ill_c_d   = accept ? fetch_illegal_c_i     : ill_c_q;
        err_d     = accept ? fetch_err_i           : err_q;
    end

    if (ResetAll) begin : g_dp_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q   <= '0;
                rdata_c_q <= '0;
                pc_q      <= '0;
                is_c_q    <= 1'b0;
                ill_c_q   <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                rdata_q   <= rdata_d;
                rdata_c_q <= rdata_c_d;
                pc_q      <= pc_d;
                is_c_q    <= is_c_d;
                ill_c_q   <= ill_c_d;
                err_q     <= err_d;
            end
        end
    end else begin : g_dp_nrst
        always_ff @(posedge clk_i) begin
            rdata_q   <= rdata_d;
            rdata_c_q <= rdata_c_d;
            pc_q      <= pc_d;
            is_c_q    <= is_c_d;
            ill_c_q   <= ill_c_d;
            err_q     <= err_d;
        end
    end

    // Separate bank shortens the fanout path from the instruction word into ALU decode.
    if (ReplicateAlu) begin : g_alu_rep
        logic [InstrW-1:0] rdata_alu_q;
        if (ResetAll) begin : g_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rdata_alu_q <= '0;
                end else begin
                    rdata_alu_q <= rdata_d;
                end
            end
        end else begin : g_nrst
            always_ff @(posedge clk_i) begin
                rdata_alu_q <= rdata_d;
            end
        end
        assign instr_rdata_alu_id_o = rdata_alu_q;
    end else begin : g_alu_shared
        assign instr_rdata_alu_id_o = rdata_q;
    end

    assign instr_valid_id_o         = valid_q;
    assign instr_first_cycle_o      = first_q;
    assign instr_cycle_cnt_o        = cnt_q;
    assign instr_rdata_id_o         = rdata_q;
    assign instr_rdata_c_id_o       = rdata_c_q;
    assign instr_is_compressed_id_o = is_c_q;
    assign illegal_c_insn_id_o      = ill_c_q;
    assign instr_fetch_err_o        = err_q;
    assign pc_id_o                  = pc_q;

endmodule

// File: tb/tb_ibex_id_instr_reg.sv
// Scoreboard bench for ibex_id_instr_reg: accepted instructions are queued and
// compared when they surface in ID; control outputs follow a small state model.
module tb_ibex_id_instr_reg;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic [15:0] fetch_rdata_c_i;
    logic        fetch_is_compressed_i;
    logic        fetch_illegal_c_i;
    logic        fetch_err_i;
    logic [31:0] fetch_pc_i;
    logic        id_done_i;
    logic        flush_i;
    logic        halt_i;
    logic        instr_valid_id_o;
    logic        instr_first_cycle_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_rdata_alu_id_o;
    logic [15:0] instr_rdata_c_id_o;
    logic        instr_is_compressed_id_o;
    logic        illegal_c_insn_id_o;
    logic        instr_fetch_err_o;
    logic [31:0] pc_id_o;
    logic [2:0]  instr_cycle_cnt_o;

    ibex_id_instr_reg #(.ResetAll(1'b1), .ReplicateAlu(1'b1)) dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .fetch_valid_i            (fetch_valid_i),
        .fetch_ready_o            (fetch_ready_o),
        .fetch_rdata_i            (fetch_rdata_i),
        .fetch_rdata_c_i          (fetch_rdata_c_i),
        .fetch_is_compressed_i    (fetch_is_compressed_i),
        .fetch_illegal_c_i        (fetch_illegal_c_i),
        .fetch_err_i              (fetch_err_i),
        .fetch_pc_i               (fetch_pc_i),
        .id_done_i                (id_done_i),
        .flush_i                  (flush_i),
        .halt_i                   (halt_i),
        .instr_valid_id_o         (instr_valid_id_o),
        .instr_first_cycle_o      (instr_first_cycle_o),
        .instr_rdata_id_o         (instr_rdata_id_o),
        .instr_rdata_alu_id_o     (instr_rdata_alu_id_o),
        .instr_rdata_c_id_o       (instr_rdata_c_id_o),
        .instr_is_compressed_id_o (instr_is_compressed_id_o),
        .illegal_c_insn_id_o      (illegal_c_insn_id_o),
        .instr_fetch_err_o        (instr_fetch_err_o),
        .pc_id_o                  (pc_id_o),
        .instr_cycle_cnt_o        (instr_cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] rdata_c;
        logic        is_c;
        logic        ill;
        logic        err;
        logic [31:0] pc;
    } exp_t;

    typedef enum int {M_EMPTY, M_FIRST, M_MULTI} m_state_e;

    int       n_checks = 0;
    int       n_fail   = 0;
    exp_t     sb[$];
    exp_t     held;
    m_state_e m_state = M_EMPTY;
    int       m_cnt   = 0;
    logic     s_acc   = 1'b0;
    logic     s_flush = 1'b0;
    logic     s_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic exp_ready();
        return (m_state == M_EMPTY || id_done_i) && !flush_i && !halt_i;
    endfunction

    // Reference state model, advanced on the inputs seen in the previous half cycle.
    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            m_state = M_EMPTY;
            m_cnt   = 0;
            sb.delete();
        end else if (s_flush) begin
            m_state = M_EMPTY;
            m_cnt   = 0;
        end else if (s_acc) begin
            m_state = M_FIRST;
            m_cnt   = 0;
        end else if (m_state != M_EMPTY) begin
            if (s_done) begin
                m_state = M_EMPTY;
                m_cnt   = 0;
            end else begin
                m_state = M_MULTI;
                m_cnt   = (m_cnt < 7) ? m_cnt + 1 : 7;
            end
        end
    end

    // Monitor: compares outputs mid-cycle, pops on first cycle, pushes on accept.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            s_acc   = 1'b0;
            s_flush = 1'b0;
            s_done  = 1'b0;
        end else begin
            check("valid", 32'(instr_valid_id_o), 32'(m_state != M_EMPTY));
            check("first", 32'(instr_first_cycle_o), 32'(m_state == M_FIRST));
            check("cnt", 32'(instr_cycle_cnt_o), 32'(m_cnt));
            check("ready", 32'(fetch_ready_o), 32'(exp_ready()));
            if (m_state == M_FIRST) begin
                check("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) held = sb.pop_front();
            end
            if (m_state != M_EMPTY) begin
                check("rdata", instr_rdata_id_o, held.rdata);
                check("rdata_alu", instr_rdata_alu_id_o, held.rdata);
                check("rdata_c", 32'(instr_rdata_c_id_o), 32'(held.rdata_c));
                check("is_c", 32'(instr_is_compressed_id_o), 32'(held.is_c));
                check("ill_c", 32'(illegal_c_insn_id_o), 32'(held.ill));
                check("fetch_err", 32'(instr_fetch_err_o), 32'(held.err));
                check("pc", pc_id_o, held.pc);
            end
            s_acc   = fetch_valid_i && exp_ready();
            s_flush = flush_i;
            s_done  = id_done_i;
            if (s_acc) sb.push_back('{fetch_rdata_i, fetch_rdata_c_i, fetch_is_compressed_i,
                                      fetch_illegal_c_i, fetch_err_i, fetch_pc_i});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] prog [3];

    initial begin
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0020_8113;
        prog[2] = 32'h0031_0193;

        rst_ni = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h1234_5678;
        fetch_rdata_c_i = 16'h4501;
        fetch_is_compressed_i = 1'b0;
        fetch_illegal_c_i = 1'b0;
        fetch_err_i = 1'b0;
        fetch_pc_i = 32'h0;
        id_done_i = 1'b0;
        flush_i = 1'b0;
        halt_i = 1'b0;

        // Reset held with fetch_valid asserted
        repeat (3) @(negedge clk_i);
        check("rst_valid", 32'(instr_valid_id_o), 32'd0);
        check("rst_first", 32'(instr_first_cycle_o), 32'd0);
        check("rst_cnt", 32'(instr_cycle_cnt_o), 32'd0);
        step();
        rst_ni = 1'b1;
        fetch_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(fetch_ready_o), 32'd1);
        check("rst_rdata", instr_rdata_id_o, 32'd0);
        check("rst_rdata_alu", instr_rdata_alu_id_o, 32'd0);

        // Back-to-back single-cycle instructions
        for (int i = 0; i < 3; i++) begin
            step();
            fetch_valid_i = 1'b1;
            fetch_rdata_i = prog[i];
            fetch_pc_i    = 32'(i * 4);
            id_done_i     = 1'b1;
            @(negedge clk_i);
            if (i > 0) begin
                check("b2b_first", 32'(instr_first_cycle_o), 32'd1);
                check("b2b_rdata", instr_rdata_id_o, prog[i-1]);
                check("b2b_cnt", 32'(instr_cycle_cnt_o), 32'd0);
            end
        end
        step();
        fetch_valid_i = 1'b0;
        @(negedge clk_i);
        check("b2b_first", 32'(instr_first_cycle_o), 32'd1);
        check("b2b_rdata_alu", instr_rdata_alu_id_o, prog[2]);

        // Multi-cycle instruction with successor waiting
        step();
        id_done_i = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0463;
        fetch_pc_i = 32'h80;
        step();
        fetch_rdata_i = 32'h0000_0013;
        fetch_pc_i = 32'h84;
        @(negedge clk_i);
        check("mc_first0", 32'(instr_first_cycle_o), 32'd1);
        check("mc_cnt0", 32'(instr_cycle_cnt_o), 32'd0);
        check("mc_ready0", 32'(fetch_ready_o), 32'd0);
        check("mc_pc", pc_id_o, 32'h80);
        step();
        @(negedge clk_i);
        check("mc_first1", 32'(instr_first_cycle_o), 32'd0);
        check("mc_cnt1", 32'(instr_cycle_cnt_o), 32'd1);
        check("mc_ready1", 32'(fetch_ready_o), 32'd0);
        step();
        id_done_i = 1'b1;
        @(negedge clk_i);
        check("mc_first2", 32'(instr_first_cycle_o), 32'd0);
        check("mc_cnt2", 32'(instr_cycle_cnt_o), 32'd2);
        check("mc_ready2", 32'(fetch_ready_o), 32'd1);
        step();
        fetch_valid_i = 1'b0;
        id_done_i = 1'b0;
        @(negedge clk_i);
        check("mc_next_first", 32'(instr_first_cycle_o), 32'd1);
        check("mc_next_rdata", instr_rdata_id_o, 32'h0000_0013);

        // Flush collides with id_done and a fetch offer while in MULTI
        step();
        @(negedge clk_i);
        check("fl_multi", 32'(instr_first_cycle_o), 32'd0);
        step();
        flush_i = 1'b1;
        id_done_i = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("fl_ready", 32'(fetch_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        id_done_i = 1'b0;
        fetch_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_valid", 32'(instr_valid_id_o), 32'd0);

        // Illegal compressed, then fetch error
        step();
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0;
        fetch_rdata_c_i = 16'h0000;
        fetch_is_compressed_i = 1'b1;
        fetch_illegal_c_i = 1'b1;
        fetch_pc_i = 32'h100;
        step();
        id_done_i = 1'b1;
        fetch_rdata_i = 32'h0000_0073;
        fetch_rdata_c_i = 16'h4501;
        fetch_is_compressed_i = 1'b0;
        fetch_illegal_c_i = 1'b0;
        fetch_err_i = 1'b1;
        fetch_pc_i = 32'h104;
        @(negedge clk_i);
        check("ic_ill", 32'(illegal_c_insn_id_o), 32'd1);
        check("ic_rdata_c", 32'(instr_rdata_c_id_o), 32'h0);
        check("ic_is_c", 32'(instr_is_compressed_id_o), 32'd1);
        step();
        fetch_valid_i = 1'b0;
        fetch_err_i = 1'b0;
        @(negedge clk_i);
        check("ic_err", 32'(instr_fetch_err_o), 32'd1);
        check("ic_ill_clr", 32'(illegal_c_insn_id_o), 32'd0);
        check("ic_first", 32'(instr_first_cycle_o), 32'd1);
        step();
        id_done_i = 1'b0;

        // Halt with long residency: counter saturates, no accept until halt drops
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0050_0293;
        fetch_pc_i = 32'h200;
        step();
        fetch_valid_i = 1'b0;
        halt_i = 1'b1;
        repeat (10) step();
        @(negedge clk_i);
        check("ht_cnt_sat", 32'(instr_cycle_cnt_o), 32'd7);
        step();
        id_done_i = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0001;
        fetch_pc_i = 32'h204;
        @(negedge clk_i);
        check("ht_ready", 32'(fetch_ready_o), 32'd0);
        step();
        id_done_i = 1'b0;
        @(negedge clk_i);
        check("ht_empty", 32'(instr_valid_id_o), 32'd0);
        check("ht_ready_e", 32'(fetch_ready_o), 32'd0);
        step();
        @(negedge clk_i);
        check("ht_still_empty", 32'(instr_valid_id_o), 32'd0);
        step();
        halt_i = 1'b0;
        @(negedge clk_i);
        check("ht_release", 32'(fetch_ready_o), 32'd1);
        step();
        fetch_valid_i = 1'b0;
        @(negedge clk_i);
        check("ht_accept", instr_rdata_id_o, 32'h0000_0001);

        // Asynchronous reset mid-instruction discards pending fetch
        step();
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0ABC;
        id_done_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid_id_o), 32'd0);
        check("ar_first", 32'(instr_first_cycle_o), 32'd0);
        check("ar_cnt", 32'(instr_cycle_cnt_o), 32'd0);
        step();
        fetch_valid_i = 1'b0;
        id_done_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ar_post_valid", 32'(instr_valid_id_o), 32'd0);
        check("ar_post_ready", 32'(fetch_ready_o), 32'd1);

        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
